// File: rtl/spi_boot_rx_if.sv
// Pin and stream bundle for the SPI boot-image receiver.
// The master side drives SPI pins and the consumer handshake; the slave side is the receiver.
interface spi_boot_rx_if;
  logic       SPI_SCK;
  logic       SPI_SS_N;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       SPI_MISO_OE;
  logic [7:0] TX_DATA;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       FRAME_ACTIVE;
  logic       OVERFLOW;
  logic       OVERFLOW_CLR;

  modport master (
    output SPI_SCK, SPI_SS_N, SPI_MOSI, TX_DATA, RX_READY, OVERFLOW_CLR,
    input  SPI_MISO, SPI_MISO_OE, RX_DATA, RX_VALID, FRAME_ACTIVE, OVERFLOW
  );

  modport slave (
    input  SPI_SCK, SPI_SS_N, SPI_MOSI, TX_DATA, RX_READY, OVERFLOW_CLR,
    output SPI_MISO, SPI_MISO_OE, RX_DATA, RX_VALID, FRAME_ACTIVE, OVERFLOW
  );
endinterface

// File: rtl/spi_boot_rx.sv
// Oversampled SPI mode-0 slave: assembles MOSI bytes into a small FIFO with a
// valid/ready output and shifts a host-supplied status byte back on MISO.
module spi_boot_rx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          CLOCK,
  input  logic          RESET,
  spi_boot_rx_if.slave  bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_shift_q, rx_shift_d;
  logic [6:0]             tx_shift_q, tx_shift_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   frame_active_q, frame_active_d;
  logic                   push_q, push_d;
  logic [7:0]             push_byte_q, push_byte_d;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [7:0]             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overflow_q, overflow_d;

  logic sck_s, ss_s, mosi_s, rise, fall;
  logic pop, full, push_ok;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;
  assign fall   = ~sck_s & sck_prev_q;

  // Synchronizers, frame FSM and the two shift registers
  always_comb begin
    sck_sync_d     = {sck_sync_q[SYNC_STAGES-2:0], bus.SPI_SCK};
    ss_sync_d      = {ss_sync_q[SYNC_STAGES-2:0], bus.SPI_SS_N};
    mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], bus.SPI_MOSI};
    sck_prev_d     = sck_s;
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    miso_d         = miso_q;
    miso_oe_d      = miso_oe_q;
    frame_active_d = frame_active_q;
    push_d         = 1'b0;
    push_byte_d    = push_byte_q;
    case (state_q)
      IDLE: begin
        if (!ss_s) begin
          state_d        = SHIFT;
          bit_cnt_d      = 3'd0;
          tx_shift_d     = bus.TX_DATA[6:0];
          miso_d         = bus.TX_DATA[7];
          miso_oe_d      = 1'b1;
          frame_active_d = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_s) begin
          // Deselect drops any partial byte: bit_cnt restarts and nothing is pushed
          state_d        = IDLE;
          bit_cnt_d      = 3'd0;
          miso_d         = 1'b0;
          miso_oe_d      = 1'b0;
          frame_active_d = 1'b0;
        end else if (rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push_d      = 1'b1;
            push_byte_d = {rx_shift_q, mosi_s};
          end
        end else if (fall) begin
          if (bit_cnt_q != 3'd0) begin
            miso_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
          end else begin
            miso_d     = bus.TX_DATA[7];
            tx_shift_d = bus.TX_DATA[6:0];
          end
        end
      end
    endcase
  end

  // Receive FIFO; a push into a full FIFO is taken only if the head pops in the same cycle
  always_comb begin
    pop        = rx_valid_q & bus.RX_READY;
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok    = push_q & (~full | pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_byte_q;
      wr_ptr_d        = PTR_W'(wr_ptr_q + PTR_W'(1));
    end
    if (pop) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
    end
    count_d    = CNT_W'(count_q + CNT_W'(push_ok) - CNT_W'(pop));
    rx_valid_d = (count_d != CNT_W'(0));
    rx_data_d  = rx_valid_d ? mem_d[rd_ptr_d] : rx_data_q;
    overflow_d = (overflow_q & ~bus.OVERFLOW_CLR) | (push_q & ~push_ok);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sck_sync_q     <= '0;
      ss_sync_q      <= '1;
      mosi_sync_q    <= '0;
      sck_prev_q     <= 1'b0;
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
      frame_active_q <= 1'b0;
      push_q         <= 1'b0;
      push_byte_q    <= 8'd0;
      mem_q          <= '{default: 8'd0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rx_data_q      <= 8'd0;
      rx_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      sck_sync_q     <= sck_sync_d;
      ss_sync_q      <= ss_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      sck_prev_q     <= sck_prev_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      miso_q         <= miso_d;
      miso_oe_q      <= miso_oe_d;
      frame_active_q <= frame_active_d;
      push_q         <= push_d;
      push_byte_q    <= push_byte_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bus.SPI_MISO     = miso_q;
  assign bus.SPI_MISO_OE  = miso_oe_q;
  assign bus.FRAME_ACTIVE = frame_active_q;
  assign bus.RX_DATA      = rx_data_q;
  assign bus.RX_VALID     = rx_valid_q;
  assign bus.OVERFLOW     = overflow_q;

endmodule

// File: tb/tb_spi_boot_rx.sv
// Bench for spi_boot_rx: an SPI master model drives frames and a queue-based
// FIFO/overflow model predicts the received stream.
module tb_spi_boot_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  spi_boot_rx_if bus();

  spi_boot_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rise8_cyc;
  int valid_rise_cyc = -1;
  logic valid_prev = 1'b0;

  logic [7:0] exp_q[$];
  logic       ov_model = 1'b0;
  logic [7:0] mo_buf [8];
  logic [7:0] tx_buf [8];

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(posedge CLOCK) begin
    #1;
    if (bus.RX_VALID === 1'b1 && !valid_prev) valid_rise_cyc = cyc;
    valid_prev = (bus.RX_VALID === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     32'(bus.SPI_MISO), 0);
    check({tag, "_miso_oe"},  32'(bus.SPI_MISO_OE), 0);
    check({tag, "_rx_data"},  32'(bus.RX_DATA), 0);
    check({tag, "_rx_valid"}, 32'(bus.RX_VALID), 0);
    check({tag, "_frame"},    32'(bus.FRAME_ACTIVE), 0);
    check({tag, "_overflow"}, 32'(bus.OVERFLOW), 0);
  endtask

  // Abstract FIFO: mode 1 = overflow-clear pulsed at push, mode 2 = ready pulsed at push
  task automatic model_push(input logic [7:0] b, input int mode);
    if (mode == 2 && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_q.push_back(b);
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
    end else begin
      ov_model = 1'b1;
    end
  endtask

  // Mode-0 master: 4 CLOCKs low then 4 high per bit; MISO sampled at the SCK rise
  task automatic xfer(input logic [7:0] mo, input int nbits, input logic [7:0] nxt_tx,
                      input int mode, output logic [7:0] mi);
    mi = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      bus.SPI_MOSI = mo[7-i];
      tick(4);
      bus.SPI_SCK = 1'b1;
      mi = {mi[6:0], bus.SPI_MISO};
      if (i == 7) rise8_cyc = cyc;
      if (i == 7 && mode != 0) begin
        tick(SYNC + 1);
        if (mode == 1) bus.OVERFLOW_CLR = 1'b1; else bus.RX_READY = 1'b1;
        tick(1);
        bus.OVERFLOW_CLR = 1'b0;
        bus.RX_READY     = 1'b0;
        for (int k = SYNC + 2; k < 4; k++) tick(1);
      end else begin
        tick(4);
      end
      if (i == 7) bus.TX_DATA = nxt_tx;
      bus.SPI_SCK = 1'b0;
    end
  endtask

  task automatic send_frame(input int nbytes, input int tail_bits, input int mode);
    logic [7:0] mi;
    bus.TX_DATA  = tx_buf[0];
    bus.SPI_SS_N = 1'b0;
    tick(4);
    check("frame_oe",     32'(bus.SPI_MISO_OE), 1);
    check("frame_active", 32'(bus.FRAME_ACTIVE), 1);
    for (int b = 0; b < nbytes; b++) begin
      xfer(mo_buf[b], 8, tx_buf[b+1], (b == nbytes - 1) ? mode : 0, mi);
      check("miso_byte", 32'(mi), 32'(tx_buf[b]));
      model_push(mo_buf[b], (b == nbytes - 1) ? mode : 0);
    end
    if (tail_bits > 0) xfer(mo_buf[nbytes], tail_bits, tx_buf[nbytes], 0, mi);
    tick(4);
    bus.SPI_SS_N = 1'b1;
    tick(SYNC + 3);
    check("gap_oe",    32'(bus.SPI_MISO_OE), 0);
    check("gap_frame", 32'(bus.FRAME_ACTIVE), 0);
  endtask

  task automatic drain(input string tag);
    int n;
    int want;
    want = exp_q.size();
    n = 0;
    while (bus.RX_VALID === 1'b1 && n < 2 * DEPTH + 2) begin
      if (exp_q.size() == 0) check({tag, "_extra"}, 1, 0);
      else                   check({tag, "_data"}, 32'(bus.RX_DATA), 32'(exp_q.pop_front()));
      bus.RX_READY = 1'b1;
      tick(1);
      bus.RX_READY = 1'b0;
      n++;
    end
    check({tag, "_count"},     32'(n), 32'(want));
    check({tag, "_valid_low"}, 32'(bus.RX_VALID), 0);
    exp_q.delete();
  endtask

  task automatic clear_overflow();
    bus.OVERFLOW_CLR = 1'b1;
    tick(1);
    bus.OVERFLOW_CLR = 1'b0;
    ov_model = 1'b0;
  endtask

  initial begin
    logic [7:0] mi;
    int nb, tail;
    bus.SPI_SCK = 1'b0; bus.SPI_SS_N = 1'b1; bus.SPI_MOSI = 1'b0;
    bus.TX_DATA = 8'd0; bus.RX_READY = 1'b0; bus.OVERFLOW_CLR = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    RESET = 1'b0;
    tick(4);

    // Single byte with latency measurement
    mo_buf[0] = 8'hA5; tx_buf[0] = 8'h3C; tx_buf[1] = 8'h3C;
    valid_rise_cyc = -1;
    send_frame(1, 0, 0);
    check("latency", 32'(valid_rise_cyc - rise8_cyc), 32'(SYNC + 2));
    check("single_data", 32'(bus.RX_DATA), 32'h A5);
    drain("single");
    check("hold_data", 32'(bus.RX_DATA), 32'hA5);

    // Burst of four with consumer stalled
    for (int i = 0; i < 4; i++) begin mo_buf[i] = 8'(i + 1); tx_buf[i] = 8'(8'h90 + i); end
    tx_buf[4] = 8'h00;
    send_frame(4, 0, 0);
    check("burst_ovf", 32'(bus.OVERFLOW), 0);
    drain("burst");

    // Overflow, then clear-vs-set precedence on a further refused push
    for (int i = 0; i < 5; i++) begin mo_buf[i] = 8'(8'h10 + i); tx_buf[i] = 8'(8'hE0 + i); end
    tx_buf[5] = 8'h00;
    send_frame(5, 0, 0);
    check("ovf_set", 32'(bus.OVERFLOW), 32'(ov_model));
    mo_buf[0] = 8'h77; tx_buf[0] = 8'h55; tx_buf[1] = 8'h55;
    send_frame(1, 0, 1);
    check("ovf_set_wins", 32'(bus.OVERFLOW), 32'(ov_model));
    clear_overflow();
    check("ovf_cleared", 32'(bus.OVERFLOW), 0);
    drain("ovf");

    // Full FIFO with a pop in the push cycle
    for (int i = 0; i < 4; i++) begin mo_buf[i] = 8'(8'h20 + i); tx_buf[i] = 8'(8'h40 + i); end
    tx_buf[4] = 8'h00;
    send_frame(4, 0, 0);
    mo_buf[0] = 8'h24; tx_buf[0] = 8'h66; tx_buf[1] = 8'h66;
    send_frame(1, 0, 2);
    check("full_pop_ovf", 32'(bus.OVERFLOW), 0);
    drain("full_pop");

    // Aborted partial byte followed by a clean frame
    mo_buf[0] = 8'hFF; tx_buf[0] = 8'h0F;
    send_frame(0, 5, 0);
    check("abort_valid", 32'(bus.RX_VALID), 0);
    mo_buf[0] = 8'h81; tx_buf[0] = 8'hC0; tx_buf[1] = 8'hC0;
    send_frame(1, 0, 0);
    drain("abort");

    // Reset mid-frame with select held low through reset
    bus.TX_DATA = 8'h12; bus.SPI_SS_N = 1'b0;
    tick(4);
    xfer(8'hE7, 3, 8'h12, 0, mi);
    RESET = 1'b1;
    tick(1);
    check_reset_outputs("midreset");
    exp_q.delete(); ov_model = 1'b0;
    bus.TX_DATA = 8'hC3;
    RESET = 1'b0;
    tick(SYNC + 2);
    check("reenter_oe", 32'(bus.SPI_MISO_OE), 1);
    xfer(8'h5A, 8, 8'hC3, 0, mi);
    check("reenter_miso", 32'(mi), 32'hC3);
    model_push(8'h5A, 0);
    tick(4);
    bus.SPI_SS_N = 1'b1;
    tick(SYNC + 3);
    drain("reset_frame");

    // Randomized frames against the queue model
    for (int f = 0; f < 20; f++) begin
      nb   = int'($urandom_range(1, 5));
      tail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int i = 0; i < 8; i++) begin
        mo_buf[i] = 8'($urandom);
        tx_buf[i] = 8'($urandom);
      end
      send_frame(nb, tail, 0);
      check("rand_ovf", 32'(bus.OVERFLOW), 32'(ov_model));
      drain("rand");
      if (ov_model) begin
        clear_overflow();
        check("rand_ovf_clr", 32'(bus.OVERFLOW), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_boot_rx.md
Name: spi_boot_rx

Overview:
- SPI slave receiver; the far-end device on the axi_spi_0 SCK/MOSI/MISO/SS pins of the MicroBlaze subsystem.
- Accepts the boot image that the MicroBlaze bootloader streams out over SPI.
- Assembles the image into bytes and buffers them in a small FIFO with a valid/ready output stream.
- Shifts a host-supplied status byte back on MISO.
- SPI mode 0 only (CPOL=0, CPHA=0), MSB first. The SPI pins are oversampled by CLOCK.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, synchronizer flops on SPI_SCK, SPI_SS_N and SPI_MOSI; 2..3.

Ports:
- CLOCK  in  1  system clock; must be >= 8x SCK frequency.
- RESET  in  1  asynchronous, active-high reset.
- SPI_SCK  in  1  SPI clock from the master.
- SPI_SS_N  in  1  slave select, active low.
- SPI_MOSI  in  1  master-out data.
- SPI_MISO  out  1  slave-out data.
- SPI_MISO_OE  out  1  MISO output enable, high while selected.
- TX_DATA  in  8  byte returned on MISO; sampled at each byte start.
- RX_DATA  out  8  FIFO head byte.
- RX_VALID  out  1  FIFO non-empty.
- RX_READY  in  1  consumer accepts the head byte when RX_VALID && RX_READY.
- FRAME_ACTIVE  out  1  synchronized select is active.
- OVERFLOW  out  1  sticky: a byte was dropped because the FIFO was full.
- OVERFLOW_CLR  in  1  clears OVERFLOW.

Behaviour:
- Reset values: SPI_MISO=0, SPI_MISO_OE=0, RX_DATA=0, RX_VALID=0, FRAME_ACTIVE=0, OVERFLOW=0. Reset also clears the FIFO, the shift registers, the bit counter and the synchronizers (SS_N synchronizer resets to 1).
- Synchronization: SCK, SS_N and MOSI each pass through SYNC_STAGES flops. One further register on synchronized SCK gives rise_pulse and fall_pulse (one CLOCK each).
- States: IDLE, SHIFT.
- IDLE -> SHIFT when synchronized SS_N is 0:
  - bit_cnt=0.
  - tx_shift loads TX_DATA.
  - SPI_MISO=TX_DATA[7].
  - SPI_MISO_OE=1, FRAME_ACTIVE=1.
- In SHIFT, on rise_pulse:
  - rx_shift={rx_shift[6:0], mosi_sync}.
  - bit_cnt increments, mod 8.
  - When bit_cnt was 7, the completed byte {rx_shift[6:0], mosi_sync} is pushed to the FIFO in the same cycle.
- In SHIFT, on fall_pulse:
  - If bit_cnt!=0: tx_shift shifts left and SPI_MISO=next bit.
  - If bit_cnt==0 (byte boundary): tx_shift reloads TX_DATA and SPI_MISO=TX_DATA[7].
- SHIFT -> IDLE when synchronized SS_N is 1, including mid-byte:
  - A partial byte is discarded; it is never pushed.
  - bit_cnt=0, SPI_MISO_OE=0, FRAME_ACTIVE=0, SPI_MISO=0.
- SCK edges in IDLE are ignored.
- Latency: with the FIFO empty, RX_VALID rises exactly SYNC_STAGES+2 CLOCK cycles after the 8th SCK rising edge at the pin.
- FIFO:
  - Pop occurs when RX_VALID && RX_READY.
  - Push is accepted if not full, or if a pop happens in the same cycle; count is unchanged in that case.
  - Pointers wrap mod FIFO_DEPTH.
  - RX_DATA is always the head entry. It holds its last value when empty.
  - Push and pop together when empty: the push is accepted and no pop occurs, since RX_VALID was 0.
- OVERFLOW:
  - Set when a push is refused; the byte is dropped.
  - Cleared by OVERFLOW_CLR.
  - If set and clear occur in the same cycle, set wins.
  - Frame reception continues after an overflow.
- RESET asserted mid-frame aborts the frame immediately. After RESET deasserts, the block re-enters SHIFT only on a new synchronized SS_N low; if SS_N is still low, it starts a fresh byte at bit 0.

Test Plan:
- Single byte: SS_N low, send 0xA5 at SCK=CLOCK/8, TX_DATA=0x3C -> master samples 0x3C on MISO; RX_DATA=0xA5; RX_VALID rises SYNC_STAGES+2 cycles after the 8th SCK rise.
- Burst of 4 bytes 0x01,0x02,0x03,0x04 with RX_READY=0, then RX_READY=1 -> bytes pop in order; OVERFLOW stays 0; RX_VALID falls after the 4th pop.
- Overflow: 5 bytes 0x10..0x14 with RX_READY=0, FIFO_DEPTH=4 -> OVERFLOW=1; FIFO holds 0x10..0x13; 0x14 is dropped.
- Overflow precedence: OVERFLOW_CLR=1 in the same cycle as a refused push -> OVERFLOW stays 1; OVERFLOW_CLR alone in the next cycle -> OVERFLOW=0.
- Full FIFO with RX_READY=1 pulsed in the push cycle -> push accepted; count stays 4; no overflow.
- Abort: SS_N high after 5 bits of 0xFF, then a new frame carrying 0x81 -> only 0x81 is received; MISO_OE drops during the gap.
- Reset mid-frame: RESET high after 3 bits -> all outputs return to reset values; a subsequent frame with 0x5A is received correctly.
